// File: rtl/packer.sv
// -----------------------------------------------------------------------------
// packer
// Packs 16-bit per-channel sample sets (1-4 enabled channels) densely into
// 64-bit words, lane 0 (bits 15:0) first. Sits between the ADC channel outputs
// and the 64-bit DMA/timestamp datapath.
//
// Ports
//   clk                 in   1   clock, rising edge
//   resetn              in   1   asynchronous active-low reset
//   enabled_chan_count  in   3   enabled channels N (0 = none, 5-7 act as 4)
//   en                  in   1   sample set valid / packer enable
//   data_in_ready       out  1   current sample set is accepted this cycle
//   data_in_0..3        in   16  channel samples, only channels 0..N-1 used
//   data_out            out  64  packed word, lane k = bits 16k+15:16k
//   data_out_valid      out  1   data_out holds a word
//   data_out_ready      in   1   downstream takes the word
// -----------------------------------------------------------------------------
module packer (
    input  logic        clk,
    input  logic        resetn,
    input  logic [2:0]  enabled_chan_count,
    input  logic        en,
    output logic        data_in_ready,
    input  logic [15:0] data_in_0,
    input  logic [15:0] data_in_1,
    input  logic [15:0] data_in_2,
    input  logic [15:0] data_in_3,
    output logic [63:0] data_out,
    output logic        data_out_valid,
    input  logic        data_out_ready
);

    // Clamp the channel count: 5-7 behave as 4 channels.
    function automatic logic [2:0] eff_chan(input logic [2:0] cnt);
        if (cnt > 3'd4) begin
            return 3'd4;
        end else begin
            return cnt;
        end
    endfunction

    logic [2:0]   n_s;          // effective channel count 0..4
    logic [1:0]   fill_r;       // lanes currently held in the accumulator (0..3)
    logic [2:0]   fill_next_s;  // fill after appending this set (0..7)
    // Only lanes 0..2 ever survive an edge (fill < 4), so just those are stored;
    // the full 7-lane view exists combinationally in merged_s.
    logic [47:0]  acc_r;
    logic [111:0] merged_s;
    logic [15:0]  chan_s [4];
    logic         accept_s;
    logic         word_s;

    assign chan_s[0] = data_in_0;
    assign chan_s[1] = data_in_1;
    assign chan_s[2] = data_in_2;
    assign chan_s[3] = data_in_3;

    assign n_s           = eff_chan(enabled_chan_count);
    assign data_in_ready = en && (n_s != 3'd0) && (!data_out_valid || data_out_ready);
    assign accept_s      = en && data_in_ready;
    assign fill_next_s   = {1'b0, fill_r} + n_s;
    // A full word exists once four or more lanes are occupied.
    assign word_s        = fill_next_s[2];

    // Append the enabled channels of the current set at lanes fill..fill+N-1.
    // Lanes at or beyond N keep the accumulator contents, so unused inputs
    // never reach the datapath.
    always_comb begin
        merged_s = {64'd0, acc_r};
        for (int k = 0; k < 4; k++) begin
            merged_s[16*(int'(fill_r) + k) +: 16] =
                (3'(k) < n_s) ? chan_s[k] : merged_s[16*(int'(fill_r) + k) +: 16];
        end
    end

    // Accumulator and fill level: cleared whenever en is low, so a partial
    // word is dropped; held when the set is not accepted.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            fill_r <= 2'd0;
            acc_r  <= 48'd0;
        end else if (!en) begin
            fill_r <= 2'd0;
            acc_r  <= 48'd0;
        end else if (accept_s) begin
            if (word_s) begin
                fill_r <= 2'(fill_next_s - 3'd4);
                acc_r  <= merged_s[111:64];
            end else begin
                fill_r <= fill_next_s[1:0];
                acc_r  <= merged_s[47:0];
            end
        end else begin
            fill_r <= fill_r;
            acc_r  <= acc_r;
        end
    end

    // Output word register: a new word loads on the accepting edge, which also
    // covers the back-to-back case where the previous word leaves on that edge.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            data_out       <= 64'd0;
            data_out_valid <= 1'b0;
        end else if (accept_s && word_s) begin
            data_out       <= merged_s[63:0];
            data_out_valid <= 1'b1;
        end else if (data_out_valid && data_out_ready) begin
            data_out       <= data_out;
            data_out_valid <= 1'b0;
        end else begin
            data_out       <= data_out;
            data_out_valid <= data_out_valid;
        end
    end

endmodule

// File: tb/tb_packer.sv
// -----------------------------------------------------------------------------
// tb_packer
// Randomized and directed stimulus for packer. A sample-stream reference model
// (a queue of 16-bit samples, four popped per word) pushes expected words into
// a scoreboard; a monitor on the falling edge checks valid/ready and pops the
// scoreboard whenever the DUT hands a word downstream.
// -----------------------------------------------------------------------------
module tb_packer;

    logic        clk = 1'b0;
    logic        resetn;
    logic [2:0]  enabled_chan_count;
    logic        en;
    logic        data_in_ready;
    logic [15:0] data_in_0, data_in_1, data_in_2, data_in_3;
    logic [63:0] data_out;
    logic        data_out_valid;
    logic        data_out_ready;

    int checks = 0;
    int fails  = 0;

    logic [15:0] samp_q [$];   // samples accepted but not yet forming a word
    logic [63:0] exp_q  [$];   // scoreboard of expected output words
    logic        accept_pred = 1'b0;
    logic        rnd_ready   = 1'b0;

    packer dut (
        .clk                (clk),
        .resetn             (resetn),
        .enabled_chan_count (enabled_chan_count),
        .en                 (en),
        .data_in_ready      (data_in_ready),
        .data_in_0          (data_in_0),
        .data_in_1          (data_in_1),
        .data_in_2          (data_in_2),
        .data_in_3          (data_in_3),
        .data_out           (data_out),
        .data_out_valid     (data_out_valid),
        .data_out_ready     (data_out_ready)
    );

    always #5 clk = ~clk;

    function automatic int eff_n(input logic [2:0] c);
        return (c > 3'd4) ? 4 : int'(c);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: expected handshake state comes from the scoreboard occupancy.
    initial begin
        bit ev;
        bit er;
        forever begin
            @(negedge clk);
            if (!resetn) begin
                accept_pred = 1'b0;
            end else begin
                ev = (exp_q.size() != 0);
                er = en && (eff_n(enabled_chan_count) != 0) && (!ev || data_out_ready);
                chk("out_valid", 64'(data_out_valid), 64'(ev));
                chk("in_ready", 64'(data_in_ready), 64'(er));
                if (data_out_valid && ev) begin
                    chk("data_out", data_out, exp_q[0]);
                    if (data_out_ready) void'(exp_q.pop_front());
                end
                accept_pred = er;
            end
        end
    end

    // Reference model: accepted samples stream into a queue, every four form a word.
    initial begin
        logic [15:0] d [4];
        logic [63:0] w;
        forever begin
            @(posedge clk);
            if (!resetn || !en) begin
                samp_q.delete();
            end else if (accept_pred) begin
                d[0] = data_in_0; d[1] = data_in_1; d[2] = data_in_2; d[3] = data_in_3;
                for (int k = 0; k < eff_n(enabled_chan_count); k++) samp_q.push_back(d[k]);
                if (samp_q.size() >= 4) begin
                    w = 64'd0;
                    for (int k = 0; k < 4; k++) w[16*k +: 16] = samp_q.pop_front();
                    exp_q.push_back(w);
                end
            end
        end
    end

    // Optional random backpressure.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rnd_ready) data_out_ready = 1'($urandom_range(0, 1));
        end
    end

    // Change the channel count with en low (one en=0 edge discards partials).
    task automatic set_mode(input logic [2:0] c);
        en = 1'b0;
        enabled_chan_count = c;
        @(posedge clk);
        #1;
    endtask

    // Present one sample set and hold it until the model says it was taken.
    task automatic send_set(input logic [15:0] a, input logic [15:0] b,
                            input logic [15:0] c, input logic [15:0] e);
        int t;
        bit taken;
        en = 1'b1;
        data_in_0 = a; data_in_1 = b; data_in_2 = c; data_in_3 = e;
        t = 0;
        taken = 1'b0;
        while (!taken && t < 200) begin
            @(posedge clk);
            taken = accept_pred;
            t++;
        end
        #1;
        if (!taken) begin
            fails++;
            $display("FAIL send_timeout: set %h,%h,%h,%h not accepted in 200 cycles", a, b, c, e);
        end
    endtask

    initial begin
        int nsets;
        resetn = 1'b0;
        en = 1'b0;
        enabled_chan_count = 3'd0;
        data_out_ready = 1'b1;
        data_in_0 = 16'd0; data_in_1 = 16'd0; data_in_2 = 16'd0; data_in_3 = 16'd0;
        #3;
        chk("reset_valid", 64'(data_out_valid), 64'd0);
        chk("reset_data", data_out, 64'd0);
        chk("reset_in_ready", 64'(data_in_ready), 64'd0);
        #9 resetn = 1'b1;
        @(posedge clk);
        #1;

        // N=4, consecutive words
        set_mode(3'd4);
        send_set(16'd1, 16'd2, 16'd3, 16'd4);
        send_set(16'd5, 16'd6, 16'd7, 16'd8);
        // N=1, unused lanes driven with junk
        set_mode(3'd1);
        for (int i = 1; i <= 8; i++) send_set(16'(i), 16'hdead, 16'hbeef, 16'hffff);
        // N=2
        set_mode(3'd2);
        send_set(16'd1, 16'd2, 16'hffff, 16'hffff);
        send_set(16'd3, 16'd4, 16'hffff, 16'hffff);
        // N=3, fill 3,2,1,0
        set_mode(3'd3);
        for (int i = 0; i < 4; i++) send_set(16'(3*i+1), 16'(3*i+2), 16'(3*i+3), 16'haaaa);
        // N=3 partial discarded by en low
        set_mode(3'd3);
        send_set(16'd1, 16'd2, 16'd3, 16'd0);
        set_mode(3'd3);
        for (int i = 1; i <= 4; i++) send_set(16'(3*i+1), 16'(3*i+2), 16'(3*i+3), 16'd0);
        // Count 7 behaves as 4
        set_mode(3'd7);
        send_set(16'h1111, 16'h2222, 16'h3333, 16'h4444);

        // Backpressure: downstream stalls 5 cycles after the first word
        set_mode(3'd4);
        data_out_ready = 1'b0;
        send_set(16'd1, 16'd2, 16'd3, 16'd4);
        fork
            send_set(16'd5, 16'd6, 16'd7, 16'd8);
            begin
                repeat (5) @(posedge clk);
                #1 data_out_ready = 1'b1;
            end
        join
        send_set(16'd9, 16'd10, 16'd11, 16'd12);

        // Reset mid-operation while a word is held
        set_mode(3'd4);
        data_out_ready = 1'b0;
        send_set(16'h0aaa, 16'h0bbb, 16'h0ccc, 16'h0ddd);
        @(negedge clk);
        #2 resetn = 1'b0;
        #1;
        chk("async_rst_valid", 64'(data_out_valid), 64'd0);
        chk("async_rst_data", data_out, 64'd0);
        exp_q.delete();
        samp_q.delete();
        en = 1'b0;
        data_out_ready = 1'b1;
        @(posedge clk);
        #3 resetn = 1'b1;
        @(posedge clk);
        #1;
        set_mode(3'd1);
        for (int i = 1; i <= 4; i++) send_set(16'(i), 16'd0, 16'd0, 16'd0);

        // Randomized segments with random backpressure
        for (int s = 0; s < 40; s++) begin
            rnd_ready = 1'b0;
            set_mode(3'($urandom_range(0, 7)));
            rnd_ready = 1'b1;
            if (enabled_chan_count == 3'd0) begin
                en = 1'b1;
                repeat (3) @(posedge clk);
                #1;
            end else begin
                nsets = $urandom_range(1, 10);
                for (int j = 0; j < nsets; j++)
                    send_set(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
            end
        end

        // Drain
        rnd_ready = 1'b0;
        #1 data_out_ready = 1'b1;
        en = 1'b0;
        for (int t = 0; t < 20 && exp_q.size() != 0; t++) @(posedge clk);
        @(negedge clk);
        chk("drain_empty", 64'(exp_q.size()), 64'd0);
        chk("drain_valid", 64'(data_out_valid), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
